irqgen_sequencer: RTL and testbench

IRQGEN_SEQUENCER -- requirements
Module: irqgen_sequencer

---
 rtl/irqgen_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_irqgen_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irqgen_sequencer.sv
`default_nettype none
// ==========================================================================
// irqgen_sequencer : job-descriptor FIFO that launches IRQ generator jobs
// Rev 1.0
// ==========================================================================
module irqgen_sequencer #(
  parameter int C_WIDTH_OF_IRQRATE = 16,
  parameter int C_WIDTH_OF_IRQAMT  = 16,
  parameter int C_QUEUE_DEPTH      = 4,
  parameter int C_GAP_CYCLES       = 3
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [3:0]                      job_line,
  input  logic [C_WIDTH_OF_IRQAMT-1:0]    job_amt,
  input  logic [C_WIDTH_OF_IRQRATE-1:0]   job_rate,
  input  logic                            flush,
  input  logic                            err_clear,
  input  logic [4:0]                      irq_handled,
  output logic                            ctrl_start,
  output logic [3:0]                      ctrl_irq_line,
  output logic [C_WIDTH_OF_IRQAMT-1:0]    ctrl_irq_amt,
  output logic [C_WIDTH_OF_IRQRATE-1:0]   ctrl_irq_rate,
  output logic                            busy,
  output logic                            job_done,
  output logic [$clog2(C_QUEUE_DEPTH):0]  queue_level,
  output logic [15:0]                     jobs_done_count,
  output logic                            err_spurious
);

  localparam int PW = $clog2(C_QUEUE_DEPTH);
  localparam int LW = PW + 1;
  localparam int AW = C_WIDTH_OF_IRQAMT;
  localparam int RW = C_WIDTH_OF_IRQRATE;
  localparam int DW = 4 + AW + RW;
  localparam int GW = $clog2(C_GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   mem_q [C_QUEUE_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            start_q, start_d;
  logic [3:0]      line_q, line_d;
  logic [AW-1:0]   amt_q, amt_d;
  logic [RW-1:0]   rate_q, rate_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     done_cnt_q, done_cnt_d;
  logic            err_q, err_d;

  logic            full, push, pop, ack, match;
  logic [DW-1:0]   head;

  assign full      = (level_q == LW'(C_QUEUE_DEPTH));
  assign job_ready = !full && !flush;
  assign push      = job_valid && job_ready;
  assign pop       = (state_q == S_IDLE) && (level_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign ack       = irq_handled[0];
  assign match     = ack && (irq_handled[4:1] == line_q);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ack_cnt_d  = ack_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    start_d    = 1'b0;
    line_d     = line_q;
    amt_d      = amt_q;
    rate_d     = rate_q;
    done_d     = 1'b0;
    done_cnt_d = done_cnt_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_LAUNCH;
          start_d = 1'b1;
          {line_d, amt_d, rate_d} = head;
        end
      end
      S_LAUNCH: begin
        ack_cnt_d = '0;
        gap_cnt_d = '0;
        if (amt_q == '0) begin
          state_d    = S_GAP;
          done_d     = 1'b1;
          done_cnt_d = done_cnt_q + 16'd1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (match) begin
          ack_cnt_d = ack_cnt_q + AW'(1);
          if (ack_cnt_d == amt_q) begin
            state_d    = S_GAP;
            gap_cnt_d  = '0;
            done_d     = 1'b1;
            done_cnt_d = done_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        if (gap_cnt_q == GW'(C_GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
    endcase

    // A fresh spurious ack outranks a simultaneous clear.
    if (ack && !(state_q == S_RUN && match)) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= {job_line, job_amt, job_rate};
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ack_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      start_q    <= 1'b0;
      line_q     <= '0;
      amt_q      <= '0;
      rate_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ack_cnt_q  <= ack_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      start_q    <= start_d;
      line_q     <= line_d;
      amt_q      <= amt_d;
      rate_q     <= rate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_cnt_q <= done_cnt_d;
      err_q      <= err_d;
    end
  end

  assign ctrl_start      = start_q;
  assign ctrl_irq_line   = line_q;
  assign ctrl_irq_amt    = amt_q;
  assign ctrl_irq_rate   = rate_q;
  assign busy            = busy_q;
  assign job_done        = done_q;
  assign queue_level     = level_q;
  assign jobs_done_count = done_cnt_q;
  assign err_spurious    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_irqgen_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_irqgen_sequencer : directed + random bench with a queue-based model
// Rev 1.0
// ==========================================================================
module tb_irqgen_sequencer;
  localparam int RW = 16, AW = 16, DEPTH = 4, GAP = 3, LW = $clog2(DEPTH) + 1;
  localparam int P_IDLE = 0, P_LAUNCH = 1, P_RUN = 2, P_GAP = 3;

  logic ACLK = 1'b0, ARESET = 1'b1, job_valid = 1'b0, flush = 1'b0, err_clear = 1'b0;
  logic [3:0] job_line = '0;
  logic [AW-1:0] job_amt = '0;
  logic [RW-1:0] job_rate = '0;
  logic [4:0] irq_handled = '0;
  logic job_ready, ctrl_start, busy, job_done, err_spurious;
  logic [3:0] ctrl_irq_line;
  logic [AW-1:0] ctrl_irq_amt;
  logic [RW-1:0] ctrl_irq_rate;
  logic [LW-1:0] queue_level;
  logic [15:0] jobs_done_count;

  irqgen_sequencer #(.C_WIDTH_OF_IRQRATE(RW), .C_WIDTH_OF_IRQAMT(AW),
                     .C_QUEUE_DEPTH(DEPTH), .C_GAP_CYCLES(GAP)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .job_valid(job_valid), .job_ready(job_ready),
    .job_line(job_line), .job_amt(job_amt), .job_rate(job_rate), .flush(flush),
    .err_clear(err_clear), .irq_handled(irq_handled), .ctrl_start(ctrl_start),
    .ctrl_irq_line(ctrl_irq_line), .ctrl_irq_amt(ctrl_irq_amt), .ctrl_irq_rate(ctrl_irq_rate),
    .busy(busy), .job_done(job_done), .queue_level(queue_level),
    .jobs_done_count(jobs_done_count), .err_spurious(err_spurious));

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [3:0]    line;
    logic [AW-1:0] amt;
    logic [RW-1:0] rate;
  } job_t;

  // Reference model: a job queue, the job in flight and countdowns.
  job_t  mq[$];
  job_t  cur = '0;
  int    mphase = P_IDLE, acks_left = 0, gap_left = 0;
  logic  m_done = 1'b0, m_err = 1'b0;
  logic [15:0] m_cnt = '0;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;
  int cyc = 0, dut_starts = 0, dut_dones = 0, last_start_cyc = 0, last_done_cyc = 0;
  int gap_run = 0, last_gap = 0;
  bit gap_on = 1'b0;
  logic [3:0] start_lines[$];
  int start_cycs[$];
  job_t last_fields = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge ACLK) begin
    if (ARESET) begin
      mq.delete(); cur = '0; mphase = P_IDLE; acks_left = 0; gap_left = 0;
      m_done = 1'b0; m_err = 1'b0; m_cnt = '0;
    end else begin
      bit full_before, push_ok, a, hit;
      full_before = (mq.size() >= DEPTH);
      push_ok = job_valid && !full_before && !flush;
      a   = irq_handled[0];
      hit = a && (irq_handled[4:1] == cur.line);
      m_done = 1'b0;
      if (a && !(mphase == P_RUN && hit)) m_err = 1'b1;
      else if (err_clear) m_err = 1'b0;
      case (mphase)
        P_IDLE: if (mq.size() > 0) begin cur = mq.pop_front(); mphase = P_LAUNCH; end
        P_LAUNCH: begin
          if (cur.amt == 0) begin mphase = P_GAP; gap_left = GAP; m_done = 1'b1; m_cnt++; end
          else begin acks_left = int'(cur.amt); mphase = P_RUN; end
        end
        P_RUN: if (hit) begin
          acks_left--;
          if (acks_left == 0) begin mphase = P_GAP; gap_left = GAP; m_done = 1'b1; m_cnt++; end
        end
        default: begin gap_left--; if (gap_left == 0) mphase = P_IDLE; end
      endcase
      if (flush) mq.delete();
      else if (push_ok) mq.push_back('{job_line, job_amt, job_rate});
    end
  end

  always @(negedge ACLK) begin
    cyc++;
    if (chk_en) begin
      chk("ctrl_start", 32'(ctrl_start), 32'(mphase == P_LAUNCH));
      chk("ctrl_irq_line", 32'(ctrl_irq_line), 32'(cur.line));
      chk("ctrl_irq_amt", 32'(ctrl_irq_amt), 32'(cur.amt));
      chk("ctrl_irq_rate", 32'(ctrl_irq_rate), 32'(cur.rate));
      chk("busy", 32'(busy), 32'(mphase != P_IDLE));
      chk("job_done", 32'(job_done), 32'(m_done));
      chk("queue_level", 32'(queue_level), 32'(mq.size()));
      chk("jobs_done_count", 32'(jobs_done_count), 32'(m_cnt));
      chk("err_spurious", 32'(err_spurious), 32'(m_err));
      chk("job_ready", 32'(job_ready), 32'((mq.size() < DEPTH) && !flush));
      if (ctrl_start === 1'b1) begin
        dut_starts++; last_start_cyc = cyc;
        start_lines.push_back(ctrl_irq_line); start_cycs.push_back(cyc);
        last_fields = '{ctrl_irq_line, ctrl_irq_amt, ctrl_irq_rate};
      end
      if (job_done === 1'b1) begin
        dut_dones++; last_done_cyc = cyc; gap_on = 1'b1; gap_run = 0;
      end
      if (gap_on) begin
        if (busy === 1'b1) gap_run++;
        else begin gap_on = 1'b0; last_gap = gap_run; end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK); #2;
    job_valid = 1'b0; flush = 1'b0; err_clear = 1'b0; irq_handled = '0;
  endtask

  task automatic push(input logic [3:0] l, input int a, input int r);
    int budget = 300;
    bit acc;
    forever begin
      acc = (mq.size() < DEPTH);
      job_valid = 1'b1; job_line = l; job_amt = AW'(a); job_rate = RW'(r);
      tick();
      if (acc) break;
      budget--;
      if (budget == 0) begin chk("push_timeout", 32'd1, 32'd0); break; end
    end
  endtask

  task automatic run_acks(input logic [3:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      int budget = 300;
      while (mphase != P_RUN && budget > 0) begin tick(); budget--; end
      if (budget == 0) begin chk("run_timeout", 32'd1, 32'd0); return; end
      irq_handled = {l, 1'b1};
      tick();
    end
  endtask

  // Waits for idle with an empty queue, acking the active line if needed.
  task automatic drain(input bit do_ack);
    int budget = 2000;
    while (!(mphase == P_IDLE && mq.size() == 0) && budget > 0) begin
      if (do_ack && mphase == P_RUN) irq_handled = {cur.line, 1'b1};
      tick(); budget--;
    end
    if (budget == 0) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int s0, d0;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    ARESET = 1'b0;
    tick();

    // Single job 3/2/5
    s0 = dut_starts; d0 = dut_dones;
    push(4'd3, 2, 5);
    run_acks(4'd3, 2);
    drain(1'b0);
    tick();
    chk("s1_starts", 32'(dut_starts - s0), 32'd1);
    chk("s1_dones", 32'(dut_dones - d0), 32'd1);
    chk("s1_fields", 32'(last_fields), 32'({4'd3, 16'd2, 16'd5}));
    chk("s1_count", 32'(jobs_done_count), 32'd1);
    chk("s1_gap", 32'(last_gap), 32'd3);

    // Five back-to-back jobs into a depth-4 queue
    start_lines.delete(); start_cycs.delete();
    for (int i = 1; i <= 5; i++) push(4'(i), 1, i);
    drain(1'b1);
    tick();
    chk("s2_nlaunch", 32'(start_lines.size()), 32'd5);
    for (int i = 0; i < start_lines.size(); i++) begin
      chk("s2_order", 32'(start_lines[i]), 32'(i + 1));
      if (i > 0) chk("s2_spacing", 32'(start_cycs[i] - start_cycs[i-1] >= 5), 32'd1);
    end

    // amt = 0
    s0 = dut_starts; d0 = dut_dones;
    push(4'd6, 0, 9);
    drain(1'b0);
    tick();
    chk("s3_starts", 32'(dut_starts - s0), 32'd1);
    chk("s3_dones", 32'(dut_dones - d0), 32'd1);
    chk("s3_done_lat", 32'(last_done_cyc - last_start_cyc), 32'd1);

    // Spurious acks
    push(4'd3, 2, 1);
    run_acks(4'd7, 2);
    chk("s4_err_set", 32'(err_spurious), 32'd1);
    run_acks(4'd3, 2);
    drain(1'b0);
    err_clear = 1'b1; tick();
    chk("s4_err_clr", 32'(err_spurious), 32'd0);
    irq_handled = {4'd3, 1'b1}; tick();
    chk("s4_err_idle", 32'(err_spurious), 32'd1);
    irq_handled = {4'd3, 1'b1}; err_clear = 1'b1; tick();
    chk("s4_set_wins", 32'(err_spurious), 32'd1);
    err_clear = 1'b1; tick();
    chk("s4_err_clr2", 32'(err_spurious), 32'd0);

    // Flush while job 1 runs
    s0 = dut_starts;
    push(4'd4, 2, 1); push(4'd5, 2, 1); push(4'd6, 2, 1);
    run_acks(4'd4, 0);
    while (mphase != P_RUN) tick();
    flush = 1'b1; tick();
    chk("s5_flush_lvl", 32'(queue_level), 32'd0);
    run_acks(4'd4, 2);
    drain(1'b0);
    repeat (5) tick();
    chk("s5_starts", 32'(dut_starts - s0), 32'd1);

    // Reset during RUN
    d0 = dut_dones;
    push(4'd2, 4, 3);
    run_acks(4'd2, 1);
    ARESET = 1'b1; tick();
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_count", 32'(jobs_done_count), 32'd0);
    ARESET = 1'b0; tick();
    chk("s6_ready", 32'(job_ready), 32'd1);
    chk("s6_nodone", 32'(dut_dones - d0), 32'd0);
    push(4'd9, 1, 2);
    run_acks(4'd9, 1);
    drain(1'b0);
    tick();
    chk("s6_relaunch", 32'(jobs_done_count), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        job_valid = 1'b1; job_line = 4'($urandom); job_amt = AW'($urandom_range(0, 3));
        job_rate = RW'($urandom);
      end
      if ($urandom_range(0, 3) == 0)
        irq_handled = {($urandom_range(0, 4) == 0) ? 4'($urandom) : cur.line, 1'b1};
      if ($urandom_range(0, 9) == 0) err_clear = 1'b1;
      if ($urandom_range(0, 99) == 0) flush = 1'b1;
      tick();
    end
    drain(1'b1);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
